// File: rtl/interval_seq_pkg.sv
// Shared types and default widths for the interval sequencer.
package interval_seq_pkg;

    localparam int unsigned NUM_W  = 24;
    localparam int unsigned CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        NEXT = 2'd3
    } state_t;

    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [CODE_W-1:0] code;
    } entry_t;

endpackage

// File: rtl/interval_seq_table.sv
// Interval table: DEPTH entries, synchronous write, asynchronous read, cleared on reset.
module interval_seq_table
    import interval_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  entry_t                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output entry_t                   rd_data_c
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/interval_sequencer.sv
// Plays a programmed list of intervals through the downstream counter, emitting one code per entry.
// Optional RUN-state watchdog enabled by defining INTERVAL_SEQ_WDOG_EN.
module interval_sequencer
    import interval_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
`ifdef INTERVAL_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_SLACK = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NUM_W-1:0]         wr_num,
    input  logic [CODE_W-1:0]        wr_code,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    output logic                     cnt_reset,
    output logic [NUM_W-1:0]         cnt_num,
    input  logic                     cnt_done,
    output logic [CODE_W-1:0]        code_out,
    output logic                     code_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     wdog_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  idx, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               is_last_c;
    logic               seq_end_c;
    logic               wdog_trip_c;
    entry_t             wr_entry_c;
    entry_t             rd_entry_c;

    logic               cnt_reset_d;
    logic [NUM_W-1:0]   cnt_num_d;
    logic [CODE_W-1:0]  code_out_d;
    logic               code_valid_d;
    logic               busy_d;
    logic               done_d;

    assign wr_entry_c.num  = wr_num;
    assign wr_entry_c.code = wr_code;

    // Read port follows the next index so LOAD outputs come straight from the table
    interval_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_entry_c),
        .rd_addr   (idx_d),
        .rd_data_c (rd_entry_c)
    );

    assign is_last_c = (LEN_W'(idx) + LEN_W'(1)) >= len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            len_q <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        len_d     = len_q;
        seq_end_c = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    len_d   = len;
                end
            end
            // cnt_num already holds this entry's target; zero-length entries skip RUN
            LOAD: state_d = (cnt_num == '0) ? NEXT : RUN;
            RUN: begin
                if (cnt_done) begin
                    state_d = NEXT;
                end else if (wdog_trip_c) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            NEXT: begin
                if (!is_last_c) begin
                    state_d = LOAD;
                    idx_d   = idx + ADDR_W'(1);
                end else if (loop_en) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    seq_end_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d   = IDLE;
            idx_d     = '0;
            seq_end_c = 1'b0;
        end
    end

    always_comb begin
        cnt_reset_d  = 1'b1;
        cnt_num_d    = cnt_num;
        code_out_d   = code_out;
        code_valid_d = 1'b0;
        busy_d       = (state_d != IDLE);
        done_d       = seq_end_c;
        case (state_d)
            LOAD: begin
                cnt_num_d    = rd_entry_c.num;
                code_out_d   = rd_entry_c.code;
                code_valid_d = 1'b1;
            end
            RUN:     cnt_reset_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reset  <= 1'b1;
            cnt_num    <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt_reset  <= cnt_reset_d;
            cnt_num    <= cnt_num_d;
            code_out   <= code_out_d;
            code_valid <= code_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef INTERVAL_SEQ_WDOG_EN
    localparam int unsigned WDOG_W = NUM_W + 1;

    logic [WDOG_W-1:0] wdog_cnt;
    logic [WDOG_W-1:0] wdog_limit_c;

    // Extra bit keeps target plus slack from wrapping
    assign wdog_limit_c = WDOG_W'(cnt_num) + WDOG_W'(WDOG_SLACK);
    assign wdog_trip_c  = (state == RUN) && (wdog_cnt >= wdog_limit_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_cnt <= (state == RUN) ? (wdog_cnt + WDOG_W'(1)) : '0;
            if (wdog_trip_c && !cnt_done) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_trip_c = 1'b0;
    assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_interval_sequencer.sv
// Directed self-checking bench for interval_sequencer (watchdog case runs when INTERVAL_SEQ_WDOG_EN is defined).
module tb_interval_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_num;
    logic [7:0]  wr_code;
    logic [3:0]  len;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        cnt_reset;
    logic [23:0] cnt_num;
    logic        cnt_done;
    logic [7:0]  code_out;
    logic        code_valid;
    logic        busy;
    logic        done;
    logic        wdog_err;

    int n_cmp = 0;
    int n_bad = 0;

    interval_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_num     (wr_num),
        .wr_code    (wr_code),
        .len        (len),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .cnt_reset  (cnt_reset),
        .cnt_num    (cnt_num),
        .cnt_done   (cnt_done),
        .code_out   (code_out),
        .code_valid (code_valid),
        .busy       (busy),
        .done       (done),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] n, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_num  = n;
        wr_code = c;
        tick();
        wr_en   = 1'b0;
    endtask

    // Entered in LOAD: checks LOAD, RUN, NEXT outputs, then steps out of NEXT
    task automatic entry(input logic [7:0] code, input logic [23:0] num, input int extra);
        chk("load_valid", 32'(code_valid), 32'd1);
        chk("load_code", 32'(code_out), 32'(code));
        chk("load_num", 32'(cnt_num), 32'(num));
        chk("load_rst", 32'(cnt_reset), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        tick();
        chk("run_rst", 32'(cnt_reset), 32'd0);
        chk("run_valid", 32'(code_valid), 32'd0);
        chk("run_num", 32'(cnt_num), 32'(num));
        repeat (extra) tick();
        chk("run_hold_rst", 32'(cnt_reset), 32'd0);
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
        chk("next_rst", 32'(cnt_reset), 32'd1);
        chk("next_done", 32'(done), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_num = '0; wr_code = '0;
        len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; cnt_done = 1'b0;
        tick();
        tick();
        chk("rst_cnt_reset", 32'(cnt_reset), 32'd1);
        chk("rst_cnt_num", 32'(cnt_num), 32'd0);
        chk("rst_code_out", 32'(code_out), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);
        reset = 1'b1;
        tick();

        wr(3'd0, 24'd5, 8'hA1);
        wr(3'd1, 24'd2, 8'hB2);
        wr(3'd2, 24'd7, 8'hC3);

        // Three-entry one-shot sequence
        len = 4'd3; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        entry(8'hA1, 24'd5, 3);
        entry(8'hB2, 24'd2, 0);
        entry(8'hC3, 24'd7, 5);
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_idle", 32'(busy), 32'd0);
        tick();
        chk("seq_done_pulse", 32'(done), 32'd0);

        // Looping two-entry sequence, rewrite entry 0 mid-RUN, then stop
        len = 4'd2; loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("loop_code0", 32'(code_out), 32'hA1);
        chk("loop_num0", 32'(cnt_num), 32'd5);
        tick();
        wr(3'd0, 24'd9, 8'hA1);
        chk("rewrite_hold", 32'(cnt_num), 32'd5);
        chk("rewrite_run", 32'(cnt_reset), 32'd0);
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
        tick();
        entry(8'hB2, 24'd2, 1);
        chk("wrap_valid", 32'(code_valid), 32'd1);
        chk("wrap_code", 32'(code_out), 32'hA1);
        chk("wrap_num", 32'(cnt_num), 32'd9);
        tick();
        tick();
        chk("wrap_run", 32'(cnt_reset), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_rst", 32'(cnt_reset), 32'd1);
        chk("stop_done", 32'(done), 32'd0);
        tick();
        chk("stop_done2", 32'(done), 32'd0);
        chk("stop_idle", 32'(busy), 32'd0);
        loop_en = 1'b0;

        // len==0 start ignored; stop beats start
        len = 4'd0; start = 1'b1;
        tick();
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_valid", 32'(code_valid), 32'd0);
        len = 4'd1; stop = 1'b1;
        tick();
        chk("stop_beats_start", 32'(busy), 32'd0);
        start = 1'b0; stop = 1'b0;

        // Zero-length entry: code emitted, RUN skipped
        wr(3'd1, 24'd0, 8'h5A);
        len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        entry(8'hA1, 24'd9, 0);
        chk("zero_valid", 32'(code_valid), 32'd1);
        chk("zero_code", 32'(code_out), 32'h5A);
        chk("zero_num", 32'(cnt_num), 32'd0);
        tick();
        chk("zero_next_rst", 32'(cnt_reset), 32'd1);
        chk("zero_next_busy", 32'(busy), 32'd1);
        chk("zero_next_valid", 32'(code_valid), 32'd0);
        tick();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_idle", 32'(busy), 32'd0);
        tick();

`ifdef INTERVAL_SEQ_WDOG_EN
        // Target 4 plus slack 16: trips at the end of the 21st RUN cycle
        wr(3'd0, 24'd4, 8'hA1);
        len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (20) tick();
        chk("wdog_still_run", 32'(cnt_reset), 32'd0);
        chk("wdog_not_yet", 32'(wdog_err), 32'd0);
        tick();
        chk("wdog_err", 32'(wdog_err), 32'd1);
        chk("wdog_idle", 32'(busy), 32'd0);
        chk("wdog_no_done", 32'(done), 32'd0);
        tick();
        chk("wdog_sticky", 32'(wdog_err), 32'd1);
`else
        chk("wdog_tied", 32'(wdog_err), 32'd0);
`endif

        // Asynchronous reset in the middle of RUN
        len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_run", 32'(cnt_reset), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_cnt_reset", 32'(cnt_reset), 32'd1);
        chk("arst_cnt_num", 32'(cnt_num), 32'd0);
        chk("arst_code_out", 32'(code_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wdog", 32'(wdog_err), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rst", 32'(cnt_reset), 32'd1);

        // Table was cleared: entry 0 now plays as a zero-length entry
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_valid", 32'(code_valid), 32'd1);
        chk("clr_num", 32'(cnt_num), 32'd0);
        chk("clr_code", 32'(code_out), 32'd0);
        tick();
        tick();
        chk("clr_done", 32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
